zacore_regwrite: RTL
====================

// Module: zacore_regwrite
// PURPOSE
//  Final pipeline stage: consumes memory-stage results, formats load data returned on i_data_read
//  one cycle after the memory stage's o_read_req, writes the register file, and forwards the retiring
//  value to execute via writeback_execute_if_t. Holds state under stall, counts retired instructions.
// PARAMETERS
//  INSTRET_W   64  width of retired-instruction counter o_instret
//  FORWARD_EN  1   1: drive o_writeback_execute_if.fwd_valid; 0: tie fwd_valid low
// PORTS
//  i_clk                   in   1    clock; all state on posedge
//  i_rst                   in   1    reset, asynchronous, active-low
//  i_memory_writeback_if   in   struct  memory_writeback_if_t from memory stage (fields below)
//  i_data_read             in   32   memory read data; valid only in first cycle the load occupies WB
//  o_rf_we                 out  1    register-file write enable
//  o_rf_waddr              out  5    register-file write index
//  o_rf_wdata              out  32   register-file write data
//  o_writeback_execute_if  out  struct  writeback_execute_if_t {fwd_valid, fwd_rd[4:0], fwd_data[31:0]}
//  o_instret               out  INSTRET_W  retired-instruction count
//  o_stall                 out  1    to memory stage: hold your output register
//  i_stall                 in   1    from hazard control: hold WB stage register, no retire
//  i_invalidate            in   1    flush: incoming instruction is discarded (bubble)
// BEHAVIOUR
//  memory_writeback_if_t: valid, rd_we, rd[4:0], result[31:0], is_load, ld_size[1:0] (0 B,1 H,2 W),
//   ld_unsigned, addr_lo[1:0].
//  Reset (async, i_rst==0): wb_valid=0, data_held=0, o_instret=0, o_rf_we=0, o_rf_waddr=0,
//   o_rf_wdata=0, fwd_valid=0, fwd_rd=0, fwd_data=0. o_stall=i_stall (combinational, also in reset).
//  Stage register: on posedge, if !i_stall: wb <= incoming; wb_valid <= in.valid & !i_invalidate.
//   If i_stall: wb unchanged. i_invalidate never kills the instruction already in WB (it is older).
//  Load data hold: i_data_read is sampled in the first cycle a load sits in WB (data_held==0):
//   held_data <= i_data_read, data_held <= 1 if i_stall. data_held clears when stage advances.
//   raw = data_held ? held_data : i_data_read.
//  Load formatting (is_load): B: lane=raw[8*addr_lo +:8]; H: lane=raw[16*addr_lo[1] +:16],
//   addr_lo[0] ignored (alignment enforced upstream); W: raw, addr_lo ignored; ld_size==3 treated as W.
//   Extend: zero if ld_unsigned else sign. Non-load: value=result.
//  Retire: retire = wb_valid & !i_stall. o_rf_we = retire & rd_we & (rd!=0), combinational;
//   o_rf_waddr=rd, o_rf_wdata=value. Write happens exactly once per instruction.
//  Forwarding (combinational): fwd_valid = FORWARD_EN & wb_valid & rd_we & (rd!=0), asserted while
//   stalled too; fwd_rd=rd; fwd_data=value.
//  o_instret: +1 on each retire cycle (registered); wraps modulo 2^INSTRET_W.
//  Simultaneous i_stall & i_invalidate: stall wins; wb held, no capture, no retire.
//  Reset mid-stall: held data and pending instruction discarded, no RF write after reset release.
// STRUCTURE
//  zacore_common: memory_writeback_if_t, LD_SIZE_B/H/W localparams, extend to writeback_execute_if_t.
//  Sub-module zacore_load_align: pure combinational (raw, size, unsigned, addr_lo) -> 32-bit value.
//  Top: stage register, load-data hold register, retire/forward logic, instret counter.
// TESTING
//  ALU result rd=5 result=0x1234_5678, no stall -> next cycle o_rf_we=1, waddr=5, wdata=0x12345678, instret=1.
//  LB addr_lo=3 signed, i_data_read=0x80xx_xxxx -> wdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  LH addr_lo=2 data=0x8001_0000 stall 3 cycles, i_data_read changes to 0 after cycle 1 -> no
//   write while stalled, fwd_data=0xFFFF_8001 throughout, single write 0xFFFF_8001 on release.
//  rd=0 with rd_we=1 -> o_rf_we=0, fwd_valid=0, instret still increments.
//  i_invalidate with incoming valid -> bubble: no write next cycle; instruction already in WB retires.
//  Assert i_rst low mid-stall with pending load -> all outputs 0 immediately, no write after release;
//   instret preset near 2^INSTRET_W-1 via forced retires -> wraps to 0.

Source files
------------

// File: rtl/zacore_regwrite_pkg.sv
// Shared types for the writeback stage: memory->writeback payload, writeback->execute
// forwarding bundle and load-size encodings.
package zacore_regwrite_pkg;

   localparam logic [1:0] LD_SIZE_B = 2'd0;
   localparam logic [1:0] LD_SIZE_H = 2'd1;
   localparam logic [1:0] LD_SIZE_W = 2'd2;

   typedef struct packed {
      logic        valid;
      logic        rd_we;
      logic [4:0]  rd;
      logic [31:0] result;
      logic        is_load;
      logic [1:0]  ld_size;
      logic        ld_unsigned;
      logic [1:0]  addr_lo;
   } memory_writeback_if_t;

   typedef struct packed {
      logic        fwd_valid;
      logic [4:0]  fwd_rd;
      logic [31:0] fwd_data;
   } writeback_execute_if_t;

endpackage

// File: rtl/zacore_regwrite_load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero extends it.
// Purely combinational; size encoding 3 falls through to a full word.
module zacore_regwrite_load_align
   import zacore_regwrite_pkg::*;
(
   input  logic [31:0] raw_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  addrLo_i,
   output logic [31:0] value_o
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   // Halfword lane uses only addr_lo[1]; misaligned halfwords are rejected upstream.
   always_comb begin
      byteLane = raw_i[8*addrLo_i +: 8];
      halfLane = addrLo_i[1] ? raw_i[31:16] : raw_i[15:0];
      case (size_i)
         LD_SIZE_B: value_o = unsigned_i ? {24'd0, byteLane} : {{24{byteLane[7]}}, byteLane};
         LD_SIZE_H: value_o = unsigned_i ? {16'd0, halfLane} : {{16{halfLane[15]}}, halfLane};
         default:   value_o = raw_i;
      endcase
   end

endmodule

// File: rtl/zacore_regwrite.sv
// Writeback stage: holds the retiring instruction, captures load data across stalls,
// writes the register file once per instruction, forwards to execute and counts retires.
module zacore_regwrite
   import zacore_regwrite_pkg::*;
#(
   parameter int INSTRET_W  = 64,
   parameter bit FORWARD_EN = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  memory_writeback_if_t  i_memory_writeback_if,
   input  logic [31:0]           i_data_read,
   output logic                  o_rf_we,
   output logic [4:0]            o_rf_waddr,
   output logic [31:0]           o_rf_wdata,
   output writeback_execute_if_t o_writeback_execute_if,
   output logic [INSTRET_W-1:0]  o_instret,
   output logic                  o_stall,
   input  logic                  i_stall,
   input  logic                  i_invalidate
);

   memory_writeback_if_t  wb_q, wb_d;
   logic                  dataHeld_q, dataHeld_d;
   logic [31:0]           heldData_q, heldData_d;
   logic [INSTRET_W-1:0]  instret_q;
   logic                  retire;
   logic                  writesRd;
   logic [31:0]           rawData;
   logic [31:0]           loadValue;
   logic [31:0]           value;

   // wb_q.valid doubles as the stage-valid flag; invalidate only kills the incoming instruction.
   always_comb begin
      wb_d = wb_q;
      if (!i_stall) begin
         wb_d       = i_memory_writeback_if;
         wb_d.valid = i_memory_writeback_if.valid & ~i_invalidate;
      end
   end

   // Load data is only presented in the first WB cycle, so keep a copy if we are stalled.
   always_comb begin
      dataHeld_d = dataHeld_q;
      heldData_d = heldData_q;
      if (!i_stall) begin
         dataHeld_d = 1'b0;
      end else if (wb_q.valid && wb_q.is_load && !dataHeld_q) begin
         heldData_d = i_data_read;
         dataHeld_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wb_q       <= '0;
         dataHeld_q <= 1'b0;
         heldData_q <= '0;
         instret_q  <= '0;
      end else begin
         wb_q       <= wb_d;
         dataHeld_q <= dataHeld_d;
         heldData_q <= heldData_d;
         if (retire) instret_q <= instret_q + INSTRET_W'(1);
      end
   end

   assign rawData = dataHeld_q ? heldData_q : i_data_read;

   zacore_regwrite_load_align uLoadAlign (
      .raw_i      (rawData),
      .size_i     (wb_q.ld_size),
      .unsigned_i (wb_q.ld_unsigned),
      .addrLo_i   (wb_q.addr_lo),
      .value_o    (loadValue)
   );

   always_comb begin
      value    = wb_q.is_load ? loadValue : wb_q.result;
      retire   = wb_q.valid & ~i_stall;
      writesRd = wb_q.rd_we & (wb_q.rd != 5'd0);

      o_rf_we    = retire & writesRd;
      o_rf_waddr = wb_q.rd;
      o_rf_wdata = value;

      o_writeback_execute_if.fwd_valid = FORWARD_EN & wb_q.valid & writesRd;
      o_writeback_execute_if.fwd_rd    = wb_q.rd;
      o_writeback_execute_if.fwd_data  = value;
   end

   assign o_instret = instret_q;
   assign o_stall   = i_stall;

endmodule
